// File: rtl/phase_unwrap.sv
// Phase unwrapper for the receive path: wrapped sample-to-sample difference,
// running unwrapped phase and a block average of the differences.
module phase_unwrap #(
  parameter int unsigned INBITS   = 19,
  parameter int unsigned FRACBITS = 10,
  parameter int unsigned ACCBITS  = 32,
  parameter int unsigned LOG2AVG  = 3
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      in_valid,
  input  logic signed [INBITS-1:0]  angle,
  output logic                      diff_valid,
  output logic signed [INBITS-1:0]  diff,
  output logic signed [ACCBITS-1:0] unwrapped,
  output logic                      avg_valid,
  output logic signed [INBITS-1:0]  avg
);

  localparam int unsigned RawW = INBITS + 1;
  localparam int unsigned SumW = INBITS + LOG2AVG;

  localparam logic signed [RawW-1:0] Half  = RawW'(180 << FRACBITS);
  localparam logic signed [RawW-1:0] NHalf = -Half;
  localparam logic signed [RawW-1:0] Full  = RawW'(360 << FRACBITS);

  typedef enum logic {StEmpty, StRun} state_e;

  state_e                     state_q, state_d;
  logic signed [INBITS-1:0]   prev_q, prev_d;
  logic signed [SumW-1:0]     sum_q, sum_d;
  logic        [LOG2AVG-1:0]  cnt_q, cnt_d;
  logic                       diff_valid_d, avg_valid_d;
  logic signed [INBITS-1:0]   diff_d, avg_d;
  logic signed [ACCBITS-1:0]  unwrapped_d;

  logic signed [RawW-1:0]     raw, wrapped;
  logic signed [INBITS-1:0]   d;
  logic signed [SumW-1:0]     sum_plus, sum_shift;

  always_comb begin
    raw = {angle[INBITS-1], angle} - {prev_q[INBITS-1], prev_q};
    if (raw >= Half) begin
      wrapped = raw - Full;
    end else if (raw < NHalf) begin
      wrapped = raw + Full;
    end else begin
      wrapped = raw;
    end
    d         = wrapped[INBITS-1:0];
    sum_plus  = sum_q + {{(SumW-INBITS){d[INBITS-1]}}, d};
    sum_shift = sum_plus >>> LOG2AVG;
  end

  always_comb begin
    state_d      = state_q;
    prev_d       = prev_q;
    sum_d        = sum_q;
    cnt_d        = cnt_q;
    diff_d       = diff;
    unwrapped_d  = unwrapped;
    avg_d        = avg;
    diff_valid_d = 1'b0;
    avg_valid_d  = 1'b0;
    if (in_valid) begin
      prev_d = angle;
      case (state_q)
        StEmpty: begin
          // First sample only seeds the chain; no difference exists yet.
          unwrapped_d = {{(ACCBITS-INBITS){angle[INBITS-1]}}, angle};
          state_d     = StRun;
        end
        StRun: begin
          diff_d       = d;
          unwrapped_d  = unwrapped + {{(ACCBITS-INBITS){d[INBITS-1]}}, d};
          diff_valid_d = 1'b1;
          if (cnt_q == {LOG2AVG{1'b1}}) begin
            avg_d       = sum_shift[INBITS-1:0];
            avg_valid_d = 1'b1;
            sum_d       = '0;
            cnt_d       = '0;
          end else begin
            sum_d = sum_plus;
            cnt_d = cnt_q + LOG2AVG'(1);
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      state_q    <= StEmpty;
      prev_q     <= '0;
      sum_q      <= '0;
      cnt_q      <= '0;
      diff       <= '0;
      unwrapped  <= '0;
      avg        <= '0;
      diff_valid <= 1'b0;
      avg_valid  <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      sum_q      <= sum_d;
      cnt_q      <= cnt_d;
      diff       <= diff_d;
      unwrapped  <= unwrapped_d;
      avg        <= avg_d;
      diff_valid <= diff_valid_d;
      avg_valid  <= avg_valid_d;
    end
  end

endmodule

// File: tb/tb_phase_unwrap.sv
// Self-checking bench for phase_unwrap: reference model plus directed literal checks.
module tb_phase_unwrap;

  logic                clock = 1'b0;
  logic                reset = 1'b1;
  logic                clear = 1'b0;
  logic                in_valid = 1'b0;
  logic signed [18:0]  angle = '0;
  logic                diff_valid, avg_valid;
  logic signed [18:0]  diff, avg;
  logic signed [31:0]  unwrapped;

  phase_unwrap #(
    .INBITS  (19),
    .FRACBITS(10),
    .ACCBITS (32),
    .LOG2AVG (3)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .clear     (clear),
    .in_valid  (in_valid),
    .angle     (angle),
    .diff_valid(diff_valid),
    .diff      (diff),
    .unwrapped (unwrapped),
    .avg_valid (avg_valid),
    .avg       (avg)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;
  int dv_cnt = 0;
  int av_cnt = 0;

  // Reference state: previous angle, unwrapped phase and the diffs of the current block.
  bit primed = 1'b0;
  int prev_m = 0;
  int exp_diff = 0, exp_unw = 0, exp_avg = 0;
  bit exp_dv = 1'b0, exp_av = 1'b0;
  int blk[$];

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic int floor_div8(input int s);
    return (s >= 0) ? s / 8 : -((-s + 7) / 8);
  endfunction

  initial forever begin
    int a, raw, d, s;
    @(posedge clock);
    a = angle;
    exp_dv = 1'b0;
    exp_av = 1'b0;
    if (reset || clear) begin
      primed = 1'b0;
      prev_m = 0;
      exp_diff = 0;
      exp_unw = 0;
      exp_avg = 0;
      blk.delete();
    end else if (in_valid) begin
      if (!primed) begin
        primed = 1'b1;
        exp_unw = a;
      end else begin
        raw = a - prev_m;
        if (raw >= 180 * 1024) d = raw - 360 * 1024;
        else if (raw < -180 * 1024) d = raw + 360 * 1024;
        else d = raw;
        exp_diff = d;
        exp_unw = exp_unw + d;
        exp_dv = 1'b1;
        blk.push_back(d);
        if (blk.size() == 8) begin
          s = 0;
          foreach (blk[i]) s += blk[i];
          exp_avg = floor_div8(s);
          exp_av = 1'b1;
          blk.delete();
        end
      end
      prev_m = a;
    end
  end

  initial forever begin
    int dv_i, av_i, diff_i, avg_i, unw_i;
    @(negedge clock);
    if (chk_en) begin
      dv_i = int'(diff_valid);
      av_i = int'(avg_valid);
      diff_i = diff;
      avg_i = avg;
      unw_i = unwrapped;
      chk("model diff_valid", dv_i, exp_dv);
      chk("model avg_valid", av_i, exp_av);
      chk("model diff", diff_i, exp_diff);
      chk("model unwrapped", unw_i, exp_unw);
      chk("model avg", avg_i, exp_avg);
      if (diff_valid) dv_cnt++;
      if (avg_valid) av_cnt++;
    end
  end

  task automatic drive(input bit v, input int a, input bit c = 1'b0, input bit r = 1'b0);
    @(negedge clock);
    in_valid = v;
    angle = 19'(a);
    clear = c;
    reset = r;
  endtask

  task automatic settle();
    @(posedge clock);
    #1;
  endtask

  function automatic int sx(input logic signed [18:0] x);
    return x;
  endfunction

  initial begin
    int dv0, av0;
    settle();
    chk_en = 1'b1;

    // Reset, then idle
    drive(0, 0, 0, 1);
    repeat (5) drive(0, 0);
    settle();
    chk("idle diff", sx(diff), 0);
    chk("idle unwrapped", unwrapped, 0);
    chk("idle avg", sx(avg), 0);
    chk("idle dv pulses", dv_cnt, 0);
    chk("idle av pulses", av_cnt, 0);

    // Basic differences
    drive(1, 10240); settle();
    chk("first dv", diff_valid, 0);
    chk("first unwrapped", unwrapped, 10240);
    drive(1, 20480); settle();
    chk("second dv", diff_valid, 1);
    chk("second diff", sx(diff), 10240);
    chk("second unwrapped", unwrapped, 20480);
    drive(1, 35840); settle();
    chk("third diff", sx(diff), 15360);
    chk("third unwrapped", unwrapped, 35840);
    drive(0, 0); settle();
    chk("strobe drops", diff_valid, 0);
    chk("diff holds", sx(diff), 15360);

    // Wrap around +-180
    drive(0, 0, 1);
    drive(1, 174080);
    drive(1, -174080); settle();
    chk("wrap+ diff", sx(diff), 20480);
    chk("wrap+ unwrapped", unwrapped, 194560);
    drive(1, 174080); settle();
    chk("wrap- diff", sx(diff), -20480);
    chk("wrap- unwrapped", unwrapped, 174080);

    // raw == HALF wraps negative
    drive(0, 0, 1);
    drive(1, 0);
    drive(1, 184320); settle();
    chk("half diff", sx(diff), -184320);
    chk("half unwrapped", unwrapped, -184320);

    // Block average, constant step
    drive(0, 0, 1);
    dv0 = dv_cnt; av0 = av_cnt;
    for (int i = 0; i < 9; i++) drive(1, i * 5120);
    settle();
    chk("avg8 dv", diff_valid, 1);
    chk("avg8 av", avg_valid, 1);
    chk("avg8 avg", sx(avg), 5120);
    drive(0, 0); drive(0, 0);
    chk("avg8 dv pulses", dv_cnt - dv0, 8);
    chk("avg8 av pulses", av_cnt - av0, 1);

    // Block average, negative floor
    drive(0, 0, 1);
    begin
      int seq[9] = '{0, 1, -1, 0, -2, -1, -3, -2, -4};
      foreach (seq[i]) drive(1, seq[i]);
    end
    settle();
    chk("floor av", avg_valid, 1);
    chk("floor avg", sx(avg), -1);

    // Clear mid-block discards partial sum
    drive(0, 0, 1);
    for (int i = 0; i < 4; i++) drive(1, i * 3000);
    drive(0, 0, 1);
    av0 = av_cnt;
    for (int i = 0; i < 8; i++) drive(1, 100000 + i * 1000);
    settle();
    chk("restart no early av", avg_valid, 0);
    drive(1, 108000); settle();
    chk("restart av", avg_valid, 1);
    chk("restart avg", sx(avg), 1000);
    drive(0, 0); drive(0, 0);
    chk("restart av pulses", av_cnt - av0, 1);

    // Clear with in_valid drops the sample
    drive(1, 12345, 1);
    drive(1, 5000); settle();
    chk("clear+valid no dv", diff_valid, 0);
    chk("clear+valid prime", unwrapped, 5000);
    drive(1, 6000); settle();
    chk("after clear diff", sx(diff), 1000);
    chk("after clear unwrapped", unwrapped, 6000);

    // Reset mid-stream
    drive(1, 7000);
    drive(1, 9000, 0, 1); settle();
    chk("reset dv", diff_valid, 0);
    chk("reset diff", sx(diff), 0);
    chk("reset unwrapped", unwrapped, 0);
    chk("reset avg", sx(avg), 0);
    drive(1, 2000);
    drive(1, 2500); settle();
    chk("post reset diff", sx(diff), 500);
    drive(0, 0); drive(0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/phase_unwrap.md
# phase_unwrap

Downstream consumer of the `phasecalc` CORDIC stage in the HilbertFilter receive path. Takes one wrapped phase sample per handshake, Q8.10 degrees, nominal range [-180, +180]. Produces:
- the wrapped sample-to-sample phase difference (instantaneous frequency);
- a running unwrapped phase;
- a block average of the difference over 2^LOG2AVG samples, for the downstream frequency/symbol decision logic.

## Interface

Parameters:
- `INBITS`, 19, width of input angle and of `diff`/`avg` (signed, Q8.10 degrees).
- `FRACBITS`, 10, fractional bits of the angle format.
- `ACCBITS`, 32, width of the unwrapped phase accumulator (signed, same LSB weight).
- `LOG2AVG`, 3, log2 of the averaging block length N.

Ports:
- `clock`  in  1  system clock. One clock domain; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `clear`  in  1  synchronous sequence restart. Same effect as `reset` on all state and outputs.
- `in_valid`  in  1  single-cycle strobe: `angle` holds a new result from `phasecalc`.
- `angle`  in  INBITS  signed input phase, Q8.10 degrees.
- `diff_valid`  out  1  single-cycle strobe: `diff` and `unwrapped` were updated.
- `diff`  out  INBITS  signed wrapped difference, range [-180, +180).
- `unwrapped`  out  ACCBITS  signed unwrapped phase.
- `avg_valid`  out  1  single-cycle strobe: `avg` was updated.
- `avg`  out  INBITS  signed mean of the last N diffs.

## Operation

- Constants: HALF = 180·2^FRACBITS = 184320; FULL = 360·2^FRACBITS = 368640.
- State machine, two states:
  - EMPTY, no previous sample. Entered at reset and on `clear`.
  - RUN.
- EMPTY + `in_valid`:
  - `prev` ← `angle`.
  - `unwrapped` ← sign-extended `angle`.
  - Go to RUN.
  - `diff_valid` stays low and `diff` is unchanged; the first sample only primes the chain.
- RUN + `in_valid`:
  - raw = `angle` − `prev`, computed at INBITS+1 bits.
  - If raw ≥ HALF, d = raw − FULL. Else if raw < −HALF, d = raw + FULL. Else d = raw.
  - `diff` ← d (fits INBITS).
  - `unwrapped` ← `unwrapped` + sign-extended d, modulo 2^ACCBITS. No saturation.
  - `prev` ← `angle`; `diff_valid` pulses.
- Averaging:
  - Sum register is INBITS+LOG2AVG bits; count register is LOG2AVG bits.
  - Each produced d is added to the sum and the count increments.
  - When the N-th d of a block is produced:
    - `avg` ← (sum + d) >>> LOG2AVG, arithmetic shift (floor).
    - `avg_valid` pulses.
    - Sum and count restart from 0 for the next block.
- `in_valid` low: no state change, and both strobes are low.
- `clear` is priority over `in_valid`: a sample presented in the same cycle is discarded.
- Inputs outside [-180, +180] are not checked; the wrap rules above apply as written.

## Timing

- Reset/clear values: `diff_valid`=0, `avg_valid`=0, `diff`=0, `unwrapped`=0, `avg`=0. Internally `prev`, sum and count are 0 and the state is EMPTY.
- Latency is 1 cycle. `in_valid` sampled at edge k gives `diff`, `unwrapped` and strobes valid after edge k (visible in cycle k+1).
- `avg_valid` coincides with the `diff_valid` of the N-th diff in a block.
- Throughput: `in_valid` may be high on every cycle; no backpressure and no ready signal.
- Outputs hold their last values between strobes.
- `reset` or `clear` in the middle of a block discards the partial sum. The next sample is treated as a first sample.

## Test plan

1. Reset, then idle 5 cycles:
   - every output is 0;
   - `diff_valid` and `avg_valid` never assert.
2. Angles 10°, 20°, 35° (10240, 20480, 35840), one per cycle:
   - no `diff_valid` for the first sample;
   - then `diff` = 10240 and 15360;
   - `unwrapped` = 10240, 20480, 35840;
   - each result appears 1 cycle after its strobe.
3. Wrap around ±180°:
   - 170° → −170° (174080 → −174080): `diff` = +20480, `unwrapped` = 194560;
   - then −170° → 170°: `diff` = −20480, `unwrapped` = 174080.
4. Edge case: 0 → +180° (184320): raw = HALF, so `diff` = −184320.
5. LOG2AVG=3, 9 back-to-back samples 0°, 5°, … 40°:
   - 8 `diff_valid` pulses, each with `diff` = 5120;
   - exactly one `avg_valid`, with `avg` = 5120, in the same cycle as the 8th diff.
   - Repeat with alternating diffs +1 LSB and −2 LSB: `avg` = floor(−4/8) = −1.
6. Interruptions:
   - `clear` after 3 diffs, then 9 samples: first `avg_valid` only after 8 new diffs.
   - `clear` together with `in_valid`: the sample is ignored, and the next sample primes with no `diff_valid`.
   - `reset` asserted mid-stream: every output returns to 0 after the next edge.
